// File: rtl/vga_stream_out_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_stream_out_if
//  Purpose  : Pixel stream handshake between an upstream image pipeline and
//             the VGA output block (valid/ready plus frame/line markers).
//  Revision : 1.0 - initial release
// ============================================================================
interface vga_stream_out_if #(
    parameter int RGB_W = 6
);
    logic [RGB_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;
    logic             sof;
    logic             eol;

    // Upstream producer side
    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready,
        input  sof,
        input  eol
    );

    // VGA output block side
    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        output sof,
        output eol
    );
endinterface
`default_nettype wire

// File: rtl/vga_stream_out.sv
`default_nettype none
// ============================================================================
//  Module   : vga_stream_out
//  Purpose  : Parametrised VGA timing generator that pulls pixels from an
//             upstream valid/ready stream and drives registered rgb/hsync/
//             vsync. Missing pixels are blanked and flagged as underflow.
//             Optional macro VGA_TEST_PATTERN_EN adds a tp_sel input that
//             replaces the stream with 8 vertical colour bars.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_stream_out #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   RGB_W    = 6,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             tp_sel,
`endif
    vga_stream_out_if.slave  stream,
    output logic [RGB_W-1:0] rgb,
    output logic             hsync,
    output logic             vsync,
    output logic             underflow,
    input  logic             uf_clr
);

    // ------------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------------
    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);

    localparam logic [c_HW-1:0] c_H_LAST     = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT      = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_H_EOL      = c_HW'(H_ACTIVE - 1);
    localparam logic [c_HW-1:0] c_H_SYNC_BEG = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_H_SYNC_END = c_HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [c_VW-1:0] c_V_LAST     = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT      = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_V_SYNC_BEG = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_V_SYNC_END = c_VW'(V_ACTIVE + V_FP + V_SYNC);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_HW-1:0]  r_h_cnt;
    logic [c_VW-1:0]  r_v_cnt;
    logic [RGB_W-1:0] r_rgb;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_underflow;

    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_active;
    logic             w_hs_zone;
    logic             w_vs_zone;
    logic             w_tp_on;
    logic             w_ready;
    logic             w_uf_set;
    logic [RGB_W-1:0] w_rgb_nxt;
    logic             w_hs_nxt;
    logic             w_vs_nxt;

    // ------------------------------------------------------------------------
    // Raster decode
    // ------------------------------------------------------------------------
    assign w_h_wrap  = (r_h_cnt == c_H_LAST);
    assign w_v_wrap  = (r_v_cnt == c_V_LAST);
    assign w_active  = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    assign w_hs_zone = (r_h_cnt >= c_H_SYNC_BEG) && (r_h_cnt < c_H_SYNC_END);
    assign w_vs_zone = (r_v_cnt >= c_V_SYNC_BEG) && (r_v_cnt < c_V_SYNC_END);

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars: bar k lights the MSB of R, G, B from bits 2, 1, 0 of k.
    localparam int                c_CW      = RGB_W / 3;
    localparam logic [c_HW+2:0]   c_BAR_DIV = (c_HW + 3)'(H_ACTIVE);

    logic [2:0]       w_bar_idx;
    logic [RGB_W-1:0] w_bar_rgb;

    assign w_tp_on   = tp_sel;
    assign w_bar_idx = 3'(({3'b000, r_h_cnt} << 3) / c_BAR_DIV);

    // Build the bar colour from the bar index
    always_comb begin
        w_bar_rgb                      = '0;
        w_bar_rgb[RGB_W-1]             = w_bar_idx[2];
        w_bar_rgb[RGB_W-1-c_CW]        = w_bar_idx[1];
        w_bar_rgb[RGB_W-1-(2*c_CW)]    = w_bar_idx[0];
    end
`else
    assign w_tp_on = 1'b0;
`endif

    // The stream is consumed only in the active area while enabled and out of
    // reset; reset gates ready so it behaves exactly like en=0.
    assign w_ready  = en && rst && w_active && !w_tp_on;
    assign w_uf_set = w_ready && !stream.pix_valid;

    assign stream.pix_ready = w_ready;
    assign stream.sof       = w_ready && (r_h_cnt == '0) && (r_v_cnt == '0);
    assign stream.eol       = w_ready && (r_h_cnt == c_H_EOL);

    // Next output values: take the pixel on a transfer, blank otherwise
    always_comb begin
        w_rgb_nxt = '0;
        if (w_ready && stream.pix_valid) begin
            w_rgb_nxt = stream.pix_data;
        end
`ifdef VGA_TEST_PATTERN_EN
        if (en && w_active && w_tp_on) begin
            w_rgb_nxt = w_bar_rgb;
        end
`endif
        w_hs_nxt = (en && w_hs_zone) ? HS_POL : ~HS_POL;
        w_vs_nxt = (en && w_vs_zone) ? VS_POL : ~VS_POL;
    end

    // Raster counters: free-run while enabled, return to frame origin when not
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!en) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + c_VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + c_HW'(1);
        end
    end

    // Pin registers: colour and syncs share one stage so they stay aligned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgb   <= '0;
            r_hsync <= ~HS_POL;
            r_vsync <= ~VS_POL;
        end else begin
            r_rgb   <= w_rgb_nxt;
            r_hsync <= w_hs_nxt;
            r_vsync <= w_vs_nxt;
        end
    end

    // Sticky underflow flag; a new underflow beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_underflow <= 1'b0;
        end else if (w_uf_set) begin
            r_underflow <= 1'b1;
        end else if (uf_clr) begin
            r_underflow <= 1'b0;
        end
    end

    assign rgb       = r_rgb;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign underflow = r_underflow;

endmodule
`default_nettype wire
